gate_bist_ctrl: RTL and testbench

- Built-in self-test sequencer for the two-input gate-primitive unit (AND, OR, NOR, NAND, XOR, XNOR, NOT, BUF).
- Drives the unit's a/b inputs through all four input combinations and samples its eight outputs.
- Compares each sample against a hardwired golden truth table, accumulates errors and reports pass/fail.
- Sits beside the gate unit; started by a test/config master.

---
 rtl/gate_bist_ctrl.sv | 150 +++++++++++++++
 tb/tb_gate_bist_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer for the two-input gate-primitive unit: sweeps {a,b}, checks gate_y against a golden table.
// Optional build macro GATE_BIST_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module gate_bist_ctrl #(
    parameter int PASSES = 1,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             gate_a,
    output logic             gate_b,
    input  logic [7:0]       gate_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       fail_mask
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_APPLY = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int PC_W = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

`ifdef GATE_BIST_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    // Golden gate_y indexed by vector v = {a,b}
    localparam logic [7:0] GOLDEN [4] = '{8'h6C, 8'h5A, 8'h9A, 8'hA3};

    logic [1:0]       state;
    logic [1:0]       vec;
    logic [PC_W-1:0]  pass_cnt;
    logic [SC_W-1:0]  settle_cnt;

    logic [7:0]       mismatch;
    logic             any_err;
    logic [ERR_W-1:0] err_next;

    always_comb begin
        mismatch = gate_y ^ GOLDEN[vec];
        any_err  = |mismatch;
        err_next = err_count;
        if (any_err && (err_count != '1)) begin
            err_next = err_count + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            vec        <= '0;
            pass_cnt   <= '0;
            settle_cnt <= '0;
            gate_a     <= 1'b0;
            gate_b     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_mask  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        state      <= S_APPLY;
                        vec        <= '0;
                        pass_cnt   <= '0;
                        settle_cnt <= '0;
                        gate_a     <= 1'b0;
                        gate_b     <= 1'b0;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        fail_mask  <= '0;
                    end
                end

                S_APPLY: begin
                    if (abort) begin
                        state  <= S_IDLE;
                        busy   <= 1'b0;
                        pass   <= 1'b0;
                        gate_a <= 1'b0;
                        gate_b <= 1'b0;
                    end else if (settle_cnt == SC_W'(SETTLE - 1)) begin
                        state      <= S_CHECK;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + SC_W'(1);
                    end
                end

                S_CHECK: begin
                    if (abort) begin
                        // Abort wins over the pending compare: counters stay as they were
                        state  <= S_IDLE;
                        busy   <= 1'b0;
                        pass   <= 1'b0;
                        gate_a <= 1'b0;
                        gate_b <= 1'b0;
                    end else begin
                        if (any_err) begin
                            fail_mask <= fail_mask | mismatch;
                            err_count <= err_next;
                        end
                        if ((STOP_ON_FAIL && any_err) ||
                            (vec == 2'd3 && pass_cnt == PC_W'(PASSES - 1))) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            pass  <= (err_next == '0);
                        end else if (vec != 2'd3) begin
                            state  <= S_APPLY;
                            vec    <= vec + 2'd1;
                            gate_a <= (vec + 2'd1) >> 1;
                            gate_b <= ~vec[0];
                        end else begin
                            state    <= S_APPLY;
                            vec      <= '0;
                            pass_cnt <= pass_cnt + PC_W'(1);
                            gate_a   <= 1'b0;
                            gate_b   <= 1'b0;
                        end
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    done   <= 1'b0;
                    busy   <= 1'b0;
                    gate_a <= 1'b0;
                    gate_b <= 1'b0;
                    if (abort) begin
                        pass <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed self-checking bench for gate_bist_ctrl with three parameterisations and injectable gate faults.
module tb_gate_bist_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Instance 1: PASSES=1, SETTLE=1, ERR_W=8
    logic       start_1, abort_1, a_1, b_1, busy_1, done_1, pass_1;
    logic [7:0] y_1, err_1, mask_1, st0_1, st1_1, inv_1;
    // Instance 3: PASSES=3
    logic       start_3, abort_3, a_3, b_3, busy_3, done_3, pass_3;
    logic [7:0] y_3, err_3, mask_3, st0_3, st1_3, inv_3;
    // Instance s: ERR_W=2, PASSES=2
    logic       start_s, abort_s, a_s, b_s, busy_s, done_s, pass_s;
    logic [1:0] err_s;
    logic [7:0] y_s, mask_s, st0_s, st1_s, inv_s;

    function automatic logic [7:0] gate_model(input logic a, input logic b);
        return {a, ~a, ~(a ^ b), a ^ b, ~(a & b), ~(a | b), a | b, a & b};
    endfunction

    assign y_1 = ((gate_model(a_1, b_1) & ~st0_1) | st1_1) ^ inv_1;
    assign y_3 = ((gate_model(a_3, b_3) & ~st0_3) | st1_3) ^ inv_3;
    assign y_s = ((gate_model(a_s, b_s) & ~st0_s) | st1_s) ^ inv_s;

    gate_bist_ctrl #(.PASSES(1), .SETTLE(1), .ERR_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_1), .abort(abort_1),
        .gate_a(a_1), .gate_b(b_1), .gate_y(y_1), .busy(busy_1), .done(done_1),
        .pass(pass_1), .err_count(err_1), .fail_mask(mask_1)
    );

    gate_bist_ctrl #(.PASSES(3), .SETTLE(1), .ERR_W(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start_3), .abort(abort_3),
        .gate_a(a_3), .gate_b(b_3), .gate_y(y_3), .busy(busy_3), .done(done_3),
        .pass(pass_3), .err_count(err_3), .fail_mask(mask_3)
    );

    gate_bist_ctrl #(.PASSES(2), .SETTLE(1), .ERR_W(2)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start_s), .abort(abort_s),
        .gate_a(a_s), .gate_b(b_s), .gate_y(y_s), .busy(busy_s), .done(done_s),
        .pass(pass_s), .err_count(err_s), .fail_mask(mask_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic done_of(input int w);
        case (w)
            1:       return done_1;
            3:       return done_3;
            default: return done_s;
        endcase
    endfunction

    // Pulse start across one edge (edge 0); returns positioned in cycle 1
    task automatic kick(input int w);
        @(negedge clk);
        case (w)
            1:       start_1 = 1'b1;
            3:       start_3 = 1'b1;
            default: start_s = 1'b1;
        endcase
        tick();
        start_1 = 1'b0;
        start_3 = 1'b0;
        start_s = 1'b0;
    endtask

    // Starts a run and returns the cycle index at which done is seen (budget on timeout)
    task automatic run_wait(input int w, input int budget, output int cyc);
        kick(w);
        cyc = 1;
        while (!done_of(w) && cyc < budget) begin
            tick();
            cyc++;
        end
    endtask

    task automatic count_done_1(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done_1) cnt++;
        end
    endtask

    int         cyc;
    int         cnt;
    logic [1:0] exp_ab;

    initial begin
        rst_n   = 1'b0;
        start_1 = 1'b0; abort_1 = 1'b0; st0_1 = '0; st1_1 = '0; inv_1 = '0;
        start_3 = 1'b0; abort_3 = 1'b0; st0_3 = '0; st1_3 = '0; inv_3 = '0;
        start_s = 1'b0; abort_s = 1'b0; st0_s = '0; st1_s = '0; inv_s = '0;
        repeat (3) @(negedge clk);
        chk("rst outs", {a_1, b_1, busy_1, done_1, pass_1, err_1, mask_1}, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("idle outs", {a_1, b_1, busy_1, done_1, pass_1, err_1, mask_1}, 32'h0);

        // Test 1: good unit, per-cycle vector timing and done at cycle 9
        kick(1);
        for (int c = 1; c <= 9; c++) begin
            if (c <= 8) begin
                exp_ab = 2'((c - 1) / 2);
                chk($sformatf("t1 ab c%0d", c), {30'b0, a_1, b_1}, {30'b0, exp_ab});
            end
            chk($sformatf("t1 busy/done c%0d", c), {busy_1, done_1}, {1'b1, c == 9});
            tick();
        end
        chk("t1 pass", pass_1, 1);
        chk("t1 err", err_1, 0);
        chk("t1 mask", mask_1, 8'h00);
        chk("t1 idle", {a_1, b_1, busy_1, done_1}, 0);

        // abort alone in IDLE leaves results untouched
        abort_1 = 1'b1;
        tick();
        abort_1 = 1'b0;
        chk("idle abort pass held", {busy_1, pass_1}, 2'b01);

        // Test 2: NOR stuck-at-0 fails only at v0
        st0_1 = 8'h04;
        run_wait(1, 60, cyc);
`ifdef GATE_BIST_STOP_ON_FAIL_EN
        chk("t2 done cyc", cyc, 3);
`else
        chk("t2 done cyc", cyc, 9);
`endif
        chk("t2 err", err_1, 1);
        chk("t2 mask", mask_1, 8'h04);
        chk("t2 pass", pass_1, 0);
        repeat (4) tick();
        chk("t2 held in idle", {busy_1, err_1, mask_1}, {1'b0, 8'd1, 8'h04});
        st0_1 = '0;

        // Test 3: BUF stuck-at-1 over three passes
        st1_3 = 8'h80;
        run_wait(3, 80, cyc);
`ifdef GATE_BIST_STOP_ON_FAIL_EN
        chk("t3 done cyc", cyc, 3);
        chk("t3 err", err_3, 1);
`else
        chk("t3 done cyc", cyc, 25);
        chk("t3 err", err_3, 6);
`endif
        chk("t3 mask", mask_3, 8'h80);
        chk("t3 pass", pass_3, 0);

        // Test 4: fully inverted unit saturates a 2-bit error count
        inv_s = 8'hFF;
        run_wait(0, 80, cyc);
`ifdef GATE_BIST_STOP_ON_FAIL_EN
        chk("t4 done cyc", cyc, 3);
        chk("t4 err", err_s, 1);
`else
        chk("t4 done cyc", cyc, 17);
        chk("t4 err", err_s, 3);
`endif
        chk("t4 mask", mask_s, 8'hFF);
        chk("t4 pass", pass_s, 0);

        // Test 6: AND stuck-at-0 fails only at the final vector
        st0_1 = 8'h01;
        run_wait(1, 60, cyc);
        chk("t6 done cyc", cyc, 9);
        chk("t6 err", err_1, 1);
        chk("t6 mask", mask_1, 8'h01);
        chk("t6 pass", pass_1, 0);
        st0_1 = '0;
        tick();

        // Test 5a: abort at cycle 4 (with a stray start) returns to IDLE at cycle 5
        kick(1);
        tick();
        tick();
        tick();
        abort_1 = 1'b1;
        start_1 = 1'b1;
        tick();
        abort_1 = 1'b0;
        start_1 = 1'b0;
        chk("t5 abort idle", {a_1, b_1, busy_1, done_1, pass_1}, 0);
        count_done_1(12, cnt);
        chk("t5 no done", cnt, 0);
        chk("t5 still idle", busy_1, 0);

        // abort beats start in IDLE
        abort_1 = 1'b1;
        start_1 = 1'b1;
        tick();
        abort_1 = 1'b0;
        start_1 = 1'b0;
        chk("t5 abort wins", busy_1, 0);
        tick();
        chk("t5 abort wins 2", busy_1, 0);

        // Test 5b: asynchronous reset mid-run
        st0_1 = 8'h04;
        kick(1);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t5 rst mid-run", {a_1, b_1, busy_1, done_1, pass_1, err_1, mask_1}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_done_1(12, cnt);
        chk("t5 rst no done", {busy_1, 8'(cnt)}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
